rr_mux8_arbiter: RTL and testbench



---
 rtl/rr_mux8_arbiter_pkg.sv | 17 +
 rtl/rr_mux8_arbiter_if.sv | 13 +
 rtl/rr_mux8_arbiter_pick8.sv | 34 +++
 rtl/rr_mux8_arbiter.sv | 88 ++++++++
 tb/tb_rr_mux8_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_mux8_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the round-robin mux8 arbiter.
package rr_mux8_arbiter_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot = N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_mux8_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_mux8_arbiter_if;
    import rr_mux8_arbiter_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             busy;

    modport master (output req, input gnt, input sel, input busy);
    modport slave  (input req, output gnt, output sel, output busy);

endinterface

// File: rtl/rr_mux8_arbiter_pick8.sv
// Combinational rotating-priority picker: first set request at or after i_ptr, wrapping 7->0.
module rr_pick8
    import rr_mux8_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [SEL_W-1:0] o_idx_c,
    output logic             o_found_c
);

    logic [N_REQ-1:0] w_rot;
    logic [SEL_W-1:0] w_first;

    // Rotate right by ptr so the fixed-priority search starts at ptr.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            w_rot[i] = i_req[SEL_W'(i) + i_ptr];
        end
    end

    always_comb begin
        w_first = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_first = SEL_W'(i);
            end
        end
    end

    assign o_idx_c   = w_first + i_ptr;
    assign o_found_c = |i_req;

endmodule

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter driving the select of the shared 8:1 mux; grants last at most HOLD_MAX cycles.
module rr_mux8_arbiter
    import rr_mux8_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_mux8_arbiter_if.slave io_arb
);

    state_e           r_state, w_state;
    logic [SEL_W-1:0] r_ptr, w_ptr;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [N_REQ-1:0] r_gnt, w_gnt;
    logic [SEL_W-1:0] r_sel, w_sel;
    logic             r_busy, w_busy;
    logic             w_release;
    logic [SEL_W-1:0] w_pick_idx;
    logic             w_pick_found;

    rr_pick8 u_pick (
        .i_req     (io_arb.req),
        .i_ptr     (r_ptr),
        .o_idx_c   (w_pick_idx),
        .o_found_c (w_pick_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_ptr   <= w_ptr;
            r_cnt   <= w_cnt;
            r_gnt   <= w_gnt;
            r_sel   <= w_sel;
            r_busy  <= w_busy;
        end
    end

    // Owner is released when it drops its request or has used its full hold budget.
    always_comb begin
        w_state   = r_state;
        w_ptr     = r_ptr;
        w_cnt     = r_cnt;
        w_gnt     = r_gnt;
        w_sel     = r_sel;
        w_busy    = r_busy;
        w_release = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_gnt   = onehot(w_pick_idx);
                    w_sel   = w_pick_idx;
                    w_busy  = 1'b1;
                    w_cnt   = CNT_W'(1);
                    w_state = GRANT;
                end
            end
            GRANT: begin
                w_release = !io_arb.req[r_sel] || (r_cnt == CNT_W'(HOLD_MAX));
                if (w_release) begin
                    w_gnt   = '0;
                    w_busy  = 1'b0;
                    w_ptr   = r_sel + SEL_W'(1);
                    w_cnt   = '0;
                    w_state = IDLE;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign io_arb.gnt  = r_gnt;
    assign io_arb.sel  = r_sel;
    assign io_arb.busy = r_busy;

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Bench for rr_mux8_arbiter: HOLD_MAX=4 and HOLD_MAX=1 builds driven in lockstep against a reference model.
module tb_rr_mux8_arbiter;

    localparam int HOLD_A = 4;
    localparam int HOLD_B = 1;

    typedef struct {
        logic [7:0] req;
        logic [7:0] a_gnt;
        logic [2:0] a_sel;
        logic [7:0] b_gnt;
        logic [2:0] b_sel;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    rr_mux8_arbiter_if a_if ();
    rr_mux8_arbiter_if b_if ();

    rr_mux8_arbiter #(.HOLD_MAX(HOLD_A)) u_dut_a (.clk(clk), .rst_n(rst_n), .io_arb(a_if));
    rr_mux8_arbiter #(.HOLD_MAX(HOLD_B)) u_dut_b (.clk(clk), .rst_n(rst_n), .io_arb(b_if));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: who owns the mux, how long, and where the search starts next.
    int   m_ptr  [2];
    int   m_cnt  [2];
    int   m_sel  [2];
    logic m_busy [2];
    int   m_hold [2];

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d]  = 0;
            m_cnt[d]  = 0;
            m_sel[d]  = 0;
            m_busy[d] = 1'b0;
        end
    endtask

    task automatic model_step(input int d, input logic [7:0] r);
        int   idx;
        logic found;
        if (!m_busy[d]) begin
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                idx = (m_ptr[d] + k) % 8;
                if (!found && r[idx]) begin
                    found     = 1'b1;
                    m_sel[d]  = idx;
                    m_cnt[d]  = 1;
                    m_busy[d] = 1'b1;
                end
            end
        end else if (!r[m_sel[d]] || m_cnt[d] == m_hold[d]) begin
            m_busy[d] = 1'b0;
            m_ptr[d]  = (m_sel[d] + 1) % 8;
            m_cnt[d]  = 0;
        end else begin
            m_cnt[d] = m_cnt[d] + 1;
        end
    endtask

    function automatic logic [7:0] m_gnt(input int d);
        return m_busy[d] ? (8'h01 << m_sel[d]) : 8'h00;
    endfunction

    task automatic compare_models();
        check("a_gnt",  32'(a_if.gnt),  32'(m_gnt(0)));
        check("a_sel",  32'(a_if.sel),  32'(m_sel[0]));
        check("a_busy", 32'(a_if.busy), 32'(m_busy[0]));
        check("b_gnt",  32'(b_if.gnt),  32'(m_gnt(1)));
        check("b_sel",  32'(b_if.sel),  32'(m_sel[1]));
        check("b_busy", 32'(b_if.busy), 32'(m_busy[1]));
    endtask

    task automatic cycle(input logic [7:0] r);
        a_if.req = r;
        b_if.req = r;
        @(posedge clk);
        model_step(0, r);
        model_step(1, r);
        #1;
        compare_models();
    endtask

    // Entered at posedge+1; reset pulses between edges and is released before the next edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_a_gnt",  32'(a_if.gnt),  32'h0);
        check("rst_a_sel",  32'(a_if.sel),  32'h0);
        check("rst_a_busy", 32'(a_if.busy), 32'h0);
        check("rst_b_gnt",  32'(b_if.gnt),  32'h0);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int          qa [$];
        int          qb [$];
        logic        pa, pb;
        logic [7:0]  r, prev;

        m_hold[0] = HOLD_A;
        m_hold[1] = HOLD_B;
        model_reset();

        vecs[0] = '{8'h01, 8'h01, 3'd0, 8'h01, 3'd0};
        vecs[1] = '{8'h01, 8'h01, 3'd0, 8'h00, 3'd0};
        vecs[2] = '{8'h01, 8'h01, 3'd0, 8'h01, 3'd0};
        vecs[3] = '{8'h01, 8'h01, 3'd0, 8'h00, 3'd0};
        vecs[4] = '{8'h01, 8'h00, 3'd0, 8'h01, 3'd0};
        vecs[5] = '{8'h01, 8'h01, 3'd0, 8'h00, 3'd0};
        vecs[6] = '{8'h01, 8'h01, 3'd0, 8'h01, 3'd0};
        vecs[7] = '{8'h01, 8'h01, 3'd0, 8'h00, 3'd0};
        vecs[8] = '{8'h01, 8'h01, 3'd0, 8'h01, 3'd0};
        vecs[9] = '{8'h01, 8'h00, 3'd0, 8'h00, 3'd0};

        rst_n    = 1'b0;
        a_if.req = 8'h00;
        b_if.req = 8'h00;
        #3;
        check("init_a_gnt",  32'(a_if.gnt),  32'h0);
        check("init_a_sel",  32'(a_if.sel),  32'h0);
        check("init_a_busy", 32'(a_if.busy), 32'h0);
        #3;
        rst_n = 1'b1;

        // Sole requester 0 held: 4-on/1-off for HOLD_MAX=4, 1-on/1-off for HOLD_MAX=1.
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].req);
            check("tbl_a_gnt",  32'(a_if.gnt),  32'(vecs[i].a_gnt));
            check("tbl_a_sel",  32'(a_if.sel),  32'(vecs[i].a_sel));
            check("tbl_a_busy", 32'(a_if.busy), 32'(|vecs[i].a_gnt));
            check("tbl_b_gnt",  32'(b_if.gnt),  32'(vecs[i].b_gnt));
            check("tbl_b_sel",  32'(b_if.sel),  32'(vecs[i].b_sel));
        end

        // All requesting: grant order must rotate 0..7 then wrap to 0.
        do_reset();
        pa = 1'b0;
        pb = 1'b0;
        for (int i = 0; i < 46; i++) begin
            cycle(8'hFF);
            if (a_if.gnt != 8'h00 && !pa) qa.push_back(int'(a_if.sel));
            if (b_if.gnt != 8'h00 && !pb) qb.push_back(int'(b_if.sel));
            pa = |a_if.gnt;
            pb = |b_if.gnt;
        end
        check("a_order_len", 32'(qa.size() >= 9), 32'h1);
        check("b_order_len", 32'(qb.size() >= 9), 32'h1);
        for (int k = 0; k < 9; k++) begin
            if (k < qa.size()) check("a_order", 32'(qa[k]), 32'(k % 8));
            if (k < qb.size()) check("b_order", 32'(qb[k]), 32'(k % 8));
        end

        // Wrap-around: ptr=3 after index 2 releases; 7 wins over 2, then 2 after the gap.
        do_reset();
        cycle(8'h04);
        check("wrap_first_sel", 32'(a_if.sel), 32'd2);
        cycle(8'h00);
        check("wrap_release", 32'(a_if.gnt), 32'h0);
        cycle(8'h84);
        check("wrap_gnt7", 32'(a_if.gnt), 32'h80);
        check("wrap_sel7", 32'(a_if.sel), 32'd7);
        for (int i = 0; i < 3; i++) cycle(8'h84);
        cycle(8'h84);
        check("wrap_gap", 32'(a_if.gnt), 32'h0);
        check("wrap_gap_sel", 32'(a_if.sel), 32'd7);
        cycle(8'h84);
        check("wrap_sel2", 32'(a_if.sel), 32'd2);
        check("wrap_gnt2", 32'(a_if.gnt), 32'h04);

        // Early release of index 5 after three granted cycles; 6 follows after the gap.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(8'h60);
            check("early_gnt5", 32'(a_if.gnt), 32'h20);
        end
        cycle(8'h40);
        check("early_drop", 32'(a_if.gnt), 32'h0);
        cycle(8'h40);
        check("early_gnt6", 32'(a_if.gnt), 32'h40);
        check("early_sel6", 32'(a_if.sel), 32'd6);

        // Asynchronous reset while index 4 owns the mux.
        do_reset();
        cycle(8'h10);
        cycle(8'h10);
        check("mid_gnt4", 32'(a_if.gnt), 32'h10);
        do_reset();
        cycle(8'hFF);
        check("post_rst_gnt0", 32'(a_if.gnt), 32'h01);
        check("post_rst_sel0", 32'(a_if.sel), 32'd0);

        // One-cycle request pulse still earns a one-cycle grant on the HOLD_MAX=1 build.
        do_reset();
        cycle(8'h08);
        check("pulse_b_gnt", 32'(b_if.gnt), 32'h08);
        cycle(8'h00);
        check("pulse_b_drop", 32'(b_if.gnt), 32'h0);
        check("pulse_b_busy", 32'(b_if.busy), 32'h0);

        // Random traffic with mostly sticky requests and occasional resets.
        do_reset();
        prev = 8'h00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = 8'($urandom);
                if ($urandom_range(0, 2) == 0) r = r & 8'($urandom) & 8'($urandom);
            end else begin
                r = prev;
            end
            prev = r;
            cycle(r);
            if ($urandom_range(0, 149) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
